// File: rtl/dpi_stream_feeder.sv
// Byte-stream feeder for pattern matchers: frames packets with load/eop
// pulses, tracks per-stream "seen" state and a per-stream enable table.
module dpi_stream_feeder #(
  parameter int LOAD_GAP = 2,
  parameter int EOP_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [5:0]  in_stream_id,
  input  logic        cfg_en_wr,
  input  logic [5:0]  cfg_en_id,
  input  logic        cfg_en_val,
  input  logic        clear_streams,
  output logic        load_state,
  output logic [5:0]  stream_id,
  output logic        new_stream_id,
  output logic        enable,
  output logic [7:0]  char_in,
  output logic        char_in_vld,
  output logic        eop,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_STREAM, S_DRAIN, S_EOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] seen_q, seen_d;
  logic [63:0] en_tbl_q, en_tbl_d;
  logic        load_q, load_d;
  logic [5:0]  sid_q, sid_d;
  logic        new_q, new_d;
  logic        en_q, en_d;
  logic [7:0]  char_q, char_d;
  logic        vld_q, vld_d;
  logic        eop_q, eop_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] drop_q, drop_d;
  logic        accept;

  // in_ready is the only combinational output; held low during reset
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state_q == S_STREAM) ||
                 ((state_q == S_IDLE) && in_valid && !in_sop);
    end
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      seen_q   <= '0;
      en_tbl_q <= '0;
      load_q   <= 1'b0;
      sid_q    <= '0;
      new_q    <= 1'b0;
      en_q     <= 1'b0;
      char_q   <= '0;
      vld_q    <= 1'b0;
      eop_q    <= 1'b0;
      pkt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      en_tbl_q <= en_tbl_d;
      load_q   <= load_d;
      sid_q    <= sid_d;
      new_q    <= new_d;
      en_q     <= en_d;
      char_q   <= char_d;
      vld_q    <= vld_d;
      eop_q    <= eop_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_sop) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (LOAD_GAP <= 2) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 16'(LOAD_GAP - 3);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_STREAM;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_STREAM: begin
        if (accept && in_eop) begin
          state_d = S_DRAIN;
          cnt_d   = 16'(EOP_GAP - 1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_EOP;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_EOP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_d   = 1'b0;
    vld_d    = 1'b0;
    eop_d    = 1'b0;
    char_d   = char_q;
    sid_d    = sid_q;
    new_d    = new_q;
    en_d     = en_q;
    pkt_d    = pkt_q;
    drop_d   = drop_q;
    seen_d   = seen_q;
    en_tbl_d = en_tbl_q;

    if ((state_q == S_IDLE) && in_valid && in_sop) begin
      load_d = 1'b1;
      sid_d  = in_stream_id;
      new_d  = !seen_q[in_stream_id];
      en_d   = en_tbl_q[in_stream_id];
    end

    if ((state_q == S_IDLE) && accept && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;

    if ((state_q == S_STREAM) && accept) begin
      char_d = in_data;
      vld_d  = 1'b1;
    end

    if (state_d == S_EOP) begin
      eop_d = 1'b1;
      pkt_d = pkt_q + 16'd1;
    end

    // matchers only persist state for enabled streams; clear overrides
    if ((state_q == S_EOP) && en_q) seen_d[sid_q] = 1'b1;
    if (clear_streams) seen_d = '0;

    if (cfg_en_wr) en_tbl_d[cfg_en_id] = cfg_en_val;
  end

  assign load_state    = load_q;
  assign stream_id     = sid_q;
  assign new_stream_id = new_q;
  assign enable        = en_q;
  assign char_in       = char_q;
  assign char_in_vld   = vld_q;
  assign eop           = eop_q;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// Bench for dpi_stream_feeder: timestamp-based reference model plus
// directed packets with hand-computed latency and state expectations.
module tb_dpi_stream_feeder;

  localparam int LG = 2;
  localparam int EG = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [5:0]  in_stream_id = '0;
  logic        cfg_en_wr = 1'b0;
  logic [5:0]  cfg_en_id = '0;
  logic        cfg_en_val = 1'b0;
  logic        clear_streams = 1'b0;
  logic        load_state;
  logic [5:0]  stream_id;
  logic        new_stream_id;
  logic        enable;
  logic [7:0]  char_in;
  logic        char_in_vld;
  logic        eop;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  dpi_stream_feeder #(.LOAD_GAP(LG), .EOP_GAP(EG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_stream_id(in_stream_id),
    .cfg_en_wr(cfg_en_wr), .cfg_en_id(cfg_en_id),
    .cfg_en_val(cfg_en_val), .clear_streams(clear_streams),
    .load_state(load_state), .stream_id(stream_id),
    .new_stream_id(new_stream_id), .enable(enable),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // model: packet timeline expressed as edge timestamps
  int          edge_n = 0;
  bit          m_busy = 0;
  bit          m_got_eop = 0;
  int          m_open = 0;
  int          m_eop_edge = -1;
  logic [63:0] m_seen = '0;
  logic [63:0] m_en = '0;
  logic        e_load = 0, e_vld = 0, e_eop = 0;
  logic        e_new = 0, e_en = 0;
  logic [5:0]  e_sid = '0;
  logic [7:0]  e_char = '0;
  logic [15:0] e_pkt = '0, e_drop = '0;
  int rec_load = 0, rec_first = -1, rec_last = 0, rec_eop = 0;
  logic obs_new = 0, obs_en = 0, obs_en_eop = 0;

  task automatic model_step();
    edge_n++;
    if (rst) begin
      m_busy = 0; m_got_eop = 0; m_eop_edge = -1;
      m_seen = '0; m_en = '0;
      e_load = 0; e_vld = 0; e_eop = 0; e_new = 0; e_en = 0;
      e_sid = '0; e_char = '0; e_pkt = '0; e_drop = '0;
      return;
    end
    e_load = 0; e_vld = 0; e_eop = 0;
    if (!m_busy) begin
      if (in_valid && in_sop) begin
        m_busy = 1; m_got_eop = 0; m_eop_edge = -1;
        e_sid = in_stream_id;
        e_new = !m_seen[in_stream_id];
        e_en = m_en[in_stream_id];
        e_load = 1;
        m_open = edge_n + LG;
        rec_load = edge_n; rec_first = -1;
      end else if (in_valid && e_drop != 16'hFFFF) begin
        e_drop = e_drop + 16'd1;
      end
    end else begin
      if (!m_got_eop && edge_n >= m_open && in_valid) begin
        e_vld = 1; e_char = in_data;
        if (rec_first < 0) rec_first = edge_n;
        if (in_eop) begin
          m_got_eop = 1; rec_last = edge_n;
          m_eop_edge = edge_n + EG;
        end
      end
      if (edge_n == m_eop_edge) begin
        e_eop = 1; e_pkt = e_pkt + 16'd1; rec_eop = edge_n;
      end
      if (m_got_eop && edge_n == m_eop_edge + 1) begin
        m_busy = 0;
        if (e_en) m_seen[e_sid] = 1'b1;
      end
    end
    if (clear_streams) m_seen = '0;
    if (cfg_en_wr) m_en[cfg_en_id] = cfg_en_val;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    bit er;
    @(negedge clk);
    if (started) begin
      er = !rst && (m_busy ? (!m_got_eop && (edge_n + 1 >= m_open))
                           : (in_valid && !in_sop));
      chk("in_ready", in_ready, er);
      chk("load_state", load_state, e_load);
      chk("char_in_vld", char_in_vld, e_vld);
      chk("char_in", char_in, e_char);
      chk("eop", eop, e_eop);
      chk("pkt_count", pkt_count, e_pkt);
      chk("drop_count", drop_count, e_drop);
      if (m_busy) begin
        chk("stream_id", stream_id, e_sid);
        chk("new_stream_id", new_stream_id, e_new);
        chk("enable", enable, e_en);
      end
      if (load_state) begin obs_new = new_stream_id; obs_en = enable; end
      if (eop) obs_en_eop = enable;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit s, input bit e,
                           input logic [5:0] id);
    bit done = 0;
    in_valid = 1; in_data = d; in_sop = s; in_eop = e; in_stream_id = id;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL beat_timeout: got no handshake, want one in 64 cycles");
    end
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic send_pkt(input logic [5:0] id, input int n,
                          input logic [7:0] base, input int gap);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 8'(i), i == 0, i == n - 1, id);
      if (gap > 0 && i != n - 1) wait_cyc(gap);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && m_busy; i++) wait_cyc(1);
    if (m_busy) begin
      n_chk++;
      $display("FAIL idle_timeout: got busy, want idle in 64 cycles");
    end
    wait_cyc(1);
  endtask

  task automatic cfg_wr(input logic [5:0] id, input logic v,
                        input logic clr);
    cfg_en_wr = 1; cfg_en_id = id; cfg_en_val = v; clear_streams = clr;
    wait_cyc(1);
    cfg_en_wr = 0; clear_streams = 0;
  endtask

  initial begin
    @(posedge clk);
    started = 1;
    wait_cyc(2);
    rst = 0;
    chk("rst_pkt", pkt_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_vld", char_in_vld, 0);

    send_beat(8'hAA, 0, 0, 6'd0);
    send_beat(8'hBB, 0, 0, 6'd0);
    chk("drop_two", drop_count, 2);

    cfg_wr(6'd5, 1, 0);
    cfg_wr(6'd9, 0, 0);

    send_pkt(6'd5, 3, 8'h11, 0);
    wait_idle();
    chk("p1_first_vld_lat", rec_first - rec_load, 2);
    chk("p1_last_vld_lat", rec_last - rec_load, 4);
    chk("p1_eop_lat", rec_eop - rec_load, 6);
    chk("p1_new", obs_new, 1);
    chk("p1_pkt_count", pkt_count, 1);

    send_pkt(6'd5, 3, 8'h21, 2);
    wait_idle();
    chk("p2_new", obs_new, 0);

    cfg_wr(6'd12, 1, 1);
    send_pkt(6'd5, 2, 8'h31, 0);
    wait_idle();
    chk("p3_new_after_clear", obs_new, 1);

    send_pkt(6'd12, 1, 8'h41, 0);
    wait_idle();
    chk("p12_en_cfg_with_clear", obs_en, 1);

    send_pkt(6'd9, 2, 8'h51, 0);
    wait_idle();
    chk("p9a_en", obs_en, 0);
    chk("p9a_en_at_eop", obs_en_eop, 0);
    send_pkt(6'd9, 2, 8'h61, 0);
    wait_idle();
    chk("p9b_new", obs_new, 1);

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (eop) begin
            clear_streams = 1;
            @(posedge clk);
            #1;
            clear_streams = 0;
            break;
          end
        end
      end
    join_none
    send_pkt(6'd5, 2, 8'h71, 0);
    wait_idle();
    wait_cyc(2);
    send_pkt(6'd5, 1, 8'h81, 0);
    wait_idle();
    chk("clear_beats_eop_set", obs_new, 1);

    in_valid = 1; in_sop = 0; in_data = 8'h55;
    wait_cyc(65540);
    in_valid = 0;
    chk("drop_saturate", drop_count, 16'hFFFF);

    wait_cyc(3);
    send_pkt(6'd7, 1, 8'h5A, 0);
    wait_idle();
    chk("sb_vld_lat", rec_first - rec_load, 2);
    chk("sb_eop_lat", rec_eop - rec_load, 4);

    for (int i = 0; i < 4; i++)
      send_beat(8'h90 + 8'(i), i == 0, 0, 6'd20);
    rst = 1;
    wait_cyc(1);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_vld", char_in_vld, 0);
    chk("abort_char", char_in, 0);
    chk("abort_sid", stream_id, 0);
    chk("abort_pkt", pkt_count, 0);
    chk("abort_drop", drop_count, 0);
    rst = 0;
    wait_cyc(6);
    chk("abort_no_eop", eop, 0);
    chk("abort_pkt_after", pkt_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dpi_stream_feeder.md
DPI_STREAM_FEEDER -- requirements
Module: dpi_stream_feeder

Interface
REQ-001 SHALL have parameter LOAD_GAP, default 2, meaning cycles from load_state to the first possible char_in_vld; legal range >=2.
REQ-002 SHALL have parameter EOP_GAP, default 2, meaning cycles from the last char_in_vld to the eop pulse; legal range >=1.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream byte valid.
REQ-006 SHALL have port in_ready  out  1  upstream byte accept; a transfer occurs when in_valid & in_ready.
REQ-007 SHALL have port in_data  in  8  packet payload byte.
REQ-008 SHALL have port in_sop  in  1  first byte of packet.
REQ-009 SHALL have port in_eop  in  1  last byte of packet.
REQ-010 SHALL have port in_stream_id  in  6  stream of packet, sampled on the sop beat.
REQ-011 SHALL have port cfg_en_wr  in  1  enable-table write strobe.
REQ-012 SHALL have port cfg_en_id  in  6  enable-table write index.
REQ-013 SHALL have port cfg_en_val  in  1  enable-table write data.
REQ-014 SHALL have port clear_streams  in  1  pulse; forget all streams.
REQ-015 SHALL have port load_state  out  1  one-cycle pulse at packet start, to matchers.
REQ-016 SHALL have port stream_id  out  6  current stream, held from load_state to eop inclusive.
REQ-017 SHALL have port new_stream_id  out  1  stream not yet saved, held like stream_id.
REQ-018 SHALL have port enable  out  1  matchers enabled for this stream, held like stream_id.
REQ-019 SHALL have port char_in  out  8  byte to matchers.
REQ-020 SHALL have port char_in_vld  out  1  char_in valid.
REQ-021 SHALL have port eop  out  1  one-cycle end-of-packet pulse to matchers.
REQ-022 SHALL have port pkt_count  out  16  packets completed, wrapping.
REQ-023 SHALL have port drop_count  out  16  bytes dropped outside packets, saturating at 0xFFFF.

Function
REQ-024 SHALL implement FSM states IDLE, LOAD, WAIT, STREAM, DRAIN, EOP; every output is registered except in_ready.
REQ-025 In IDLE, in_valid & in_sop SHALL latch in_stream_id without consuming the byte (in_ready=0) and go to LOAD.
REQ-026 In IDLE, in_valid & ~in_sop SHALL consume the byte (in_ready=1), drop it and increment drop_count.
REQ-027 In LOAD, load_state=1 for exactly one cycle; new_stream_id=~seen[id] and enable=en_tbl[id] SHALL be latched in the same cycle.
REQ-028 WAIT SHALL last LOAD_GAP-2 cycles (zero cycles when LOAD_GAP=2), then enter STREAM.
REQ-029 in_ready SHALL be 1 in STREAM only (except REQ-026); an accepted byte SHALL appear on char_in with char_in_vld=1 the next cycle, so the first char_in_vld is no earlier than load_state+LOAD_GAP.
REQ-030 In STREAM, with in_valid=0, char_in_vld SHALL be 0 and char_in SHALL hold its value; stalls have no length limit.
REQ-031 In STREAM, in_sop on any beat other than the opening one SHALL be ignored and the byte forwarded.
REQ-032 An accepted beat with in_eop=1 SHALL move to DRAIN; DRAIN SHALL last EOP_GAP-1 cycles after the cycle of the final char_in_vld, then enter EOP.
REQ-033 In EOP, eop=1 for exactly one cycle with stream_id/new_stream_id/enable still held, and pkt_count increments mod 2^16; next state IDLE.
REQ-034 At EOP, if enable=1, seen[id] SHALL be set; if enable=0, seen SHALL be unchanged (matchers save no state).
REQ-035 A single-beat packet (in_sop & in_eop) SHALL produce load_state, one char_in_vld, then eop per REQ-029/032.
REQ-036 cfg_en_wr SHALL write en_tbl[cfg_en_id]=cfg_en_val on the next edge; writes during a packet SHALL NOT change the latched enable.
REQ-037 clear_streams SHALL zero all 64 seen bits; if it coincides with an EOP-cycle set, clear SHALL win.
REQ-038 A cfg write and clear_streams in the same cycle SHALL both take effect.

Reset
REQ-039 rst SHALL force IDLE, zero seen and en_tbl, and zero every output (in_ready=0, load_state=0, char_in_vld=0, eop=0, counts 0), including mid-packet; no eop is emitted for an aborted packet.

Verification
REQ-040 en_tbl[5]=1; 3-byte packet id 5, LOAD_GAP=2, EOP_GAP=2 -> load_state at L, new_stream_id=1, char_in_vld at L+2..L+4, eop at L+6, seen[5]=1, pkt_count=1.
REQ-041 Second packet id 5 -> new_stream_id=0; after clear_streams, third packet id 5 -> new_stream_id=1.
REQ-042 en_tbl[9]=0, packet id 9 -> enable=0 through eop, seen[9] stays 0, next packet id 9 gives new_stream_id=1.
REQ-043 Non-sop bytes 0xAA,0xBB in IDLE -> drop_count=2, no load_state; then 0xFFFF+ drops -> drop_count stays 0xFFFF.
REQ-044 Single-beat packet with in_valid gaps before it, then rst asserted mid-stream of a 10-byte packet -> all outputs 0 next cycle, no eop, pkt_count=0.
